// File: rtl/and_gate_pkg.sv
// Shared constants and helpers for the and_gate primitive.
package and_gate_pkg;

    localparam int unsigned WIDTH_DEF   = 1;
    localparam int unsigned LATENCY_DEF = 1;
    localparam int unsigned LATENCY_MAX = 4;
    localparam int unsigned CNT_W_DEF   = 16;

    function automatic bit latency_legal(input int unsigned lat);
        return (lat >= 1) && (lat <= LATENCY_MAX);
    endfunction

endpackage

// File: rtl/and_gate_stage.sv
// One resettable valid/data pipeline register; data holds while valid is low.
module and_gate_stage #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i;
            // Holding keeps idle data deterministic without extra toggling.
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/and_gate.sv
// Bitwise AND with a combinational output, a LATENCY-deep valid-tagged
// registered path, an all-ones flag and a saturating all-ones hit counter.
module and_gate
    import and_gate_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned LATENCY = LATENCY_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] aa,
    input  logic [WIDTH-1:0] bb,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out1_q,
    output logic             out_valid,
    output logic             all_ones,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int unsigned DataW = WIDTH;

    typedef struct packed {
        logic             valid;
        logic [DataW-1:0] data;
    } stage_t;

    if (!latency_legal(LATENCY)) begin : gen_bad_latency
        $error("and_gate: LATENCY %0d outside 1..%0d", LATENCY, LATENCY_MAX);
    end

    logic [DataW-1:0] and_res;
    stage_t           stage_in;
    stage_t           stage_out;
    logic             vld_s [LATENCY+1];
    logic [DataW-1:0] dat_s [LATENCY+1];

    assign and_res  = aa & bb;
    assign out1     = and_res;
    assign stage_in = '{valid: in_valid, data: and_res};

    assign vld_s[0] = stage_in.valid;
    assign dat_s[0] = stage_in.data;

    for (genvar i = 0; i < LATENCY; i++) begin : gen_stage
        and_gate_stage #(
            .WIDTH (DataW)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .valid_i (vld_s[i]),
            .data_i  (dat_s[i]),
            .valid_o (vld_s[i+1]),
            .data_o  (dat_s[i+1])
        );
    end

    assign stage_out = '{valid: vld_s[LATENCY], data: dat_s[LATENCY]};
    assign out1_q    = stage_out.data;
    assign out_valid = stage_out.valid;
    assign all_ones  = stage_out.valid & (&stage_out.data);

    // Hit counter tracks accepted inputs directly, independent of LATENCY.
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             hit;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    assign hit = in_valid & (&and_res);

    always_comb begin
        cnt_d = cnt_q;
        if (hit && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt = cnt_q;

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate across four parameterisations.
module tb_and_gate;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // a: W1 L1, b: W8 L3, c: W1 L4, d: W1 L1 CNT_W=3
    logic        a_aa, a_bb, a_iv, a_o1, a_q, a_ov, a_all;
    logic [15:0] a_cnt;
    logic [7:0]  b_aa, b_bb, b_o1, b_q;
    logic        b_iv, b_ov, b_all;
    logic [15:0] b_cnt;
    logic        c_aa, c_bb, c_iv, c_o1, c_q, c_ov, c_all;
    logic [15:0] c_cnt;
    logic        d_aa, d_bb, d_iv, d_o1, d_q, d_ov, d_all;
    logic [2:0]  d_cnt;

    and_gate #(.WIDTH(1), .LATENCY(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .aa(a_aa), .bb(a_bb), .in_valid(a_iv), .out1(a_o1),
        .out1_q(a_q), .out_valid(a_ov), .all_ones(a_all), .hit_cnt(a_cnt)
    );

    and_gate #(.WIDTH(8), .LATENCY(3), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .aa(b_aa), .bb(b_bb), .in_valid(b_iv), .out1(b_o1),
        .out1_q(b_q), .out_valid(b_ov), .all_ones(b_all), .hit_cnt(b_cnt)
    );

    and_gate #(.WIDTH(1), .LATENCY(4), .CNT_W(16)) u_dut_c (
        .clk(clk), .rst(rst), .aa(c_aa), .bb(c_bb), .in_valid(c_iv), .out1(c_o1),
        .out1_q(c_q), .out_valid(c_ov), .all_ones(c_all), .hit_cnt(c_cnt)
    );

    and_gate #(.WIDTH(1), .LATENCY(1), .CNT_W(3)) u_dut_d (
        .clk(clk), .rst(rst), .aa(d_aa), .bb(d_bb), .in_valid(d_iv), .out1(d_o1),
        .out1_q(d_q), .out_valid(d_ov), .all_ones(d_all), .hit_cnt(d_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] pats [4];
    logic       ov_exp [8];

    initial begin
        checks = 0;
        errors = 0;
        pats   = '{2'b00, 2'b01, 2'b10, 2'b11};
        ov_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset with dut_a offered an all-ones sample that must be ignored.
        rst  = 1'b1;
        a_aa = 1'b1; a_bb = 1'b1; a_iv = 1'b1;
        b_aa = '0;   b_bb = '0;   b_iv = 1'b0;
        c_aa = 1'b0; c_bb = 1'b0; c_iv = 1'b0;
        d_aa = 1'b0; d_bb = 1'b0; d_iv = 1'b0;
        tick(); tick(); tick();
        check("rst_out1_live", 32'(a_o1), 32'd1);
        check("rst_a_ov", 32'(a_ov), 32'd0);
        check("rst_a_q", 32'(a_q), 32'd0);
        check("rst_a_all", 32'(a_all), 32'd0);
        check("rst_a_cnt", 32'(a_cnt), 32'd0);
        check("rst_b_q", 32'(b_q), 32'd0);
        check("rst_b_ov", 32'(b_ov), 32'd0);

        // Truth table on W1 L1.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_aa = pats[i][1];
            a_bb = pats[i][0];
            #1;
            check($sformatf("tt_out1_%0d", i), 32'(a_o1), 32'(i == 3));
            tick();
            check($sformatf("tt_q_%0d", i), 32'(a_q), 32'(i == 3));
            check($sformatf("tt_ov_%0d", i), 32'(a_ov), 32'd1);
            check($sformatf("tt_all_%0d", i), 32'(a_all), 32'(i == 3));
            check($sformatf("tt_cnt_%0d", i), 32'(a_cnt), 32'(i == 3));
        end
        a_iv = 1'b0;

        // W8 L3 back-to-back samples.
        b_aa = 8'hF0; b_bb = 8'h3C; b_iv = 1'b1;
        #1;
        check("b_out1", 32'(b_o1), 32'h30);
        tick();
        b_aa = 8'hFF; b_bb = 8'hFF;
        check("b_ov_e1", 32'(b_ov), 32'd0);
        tick();
        b_iv = 1'b0; b_aa = 8'h00; b_bb = 8'h00;
        check("b_ov_e2", 32'(b_ov), 32'd0);
        tick();
        check("b_q_e3", 32'(b_q), 32'h30);
        check("b_ov_e3", 32'(b_ov), 32'd1);
        check("b_all_e3", 32'(b_all), 32'd0);
        tick();
        check("b_q_e4", 32'(b_q), 32'hFF);
        check("b_ov_e4", 32'(b_ov), 32'd1);
        check("b_all_e4", 32'(b_all), 32'd1);
        tick();
        check("b_ov_e5", 32'(b_ov), 32'd0);
        check("b_all_e5", 32'(b_all), 32'd0);
        check("b_cnt", 32'(b_cnt), 32'd1);

        // in_valid 1,0,1 through L4.
        c_aa = 1'b1; c_bb = 1'b1;
        for (int k = 0; k < 8; k++) begin
            c_iv = (k == 0 || k == 2);
            #1;
            check($sformatf("c_out1_%0d", k), 32'(c_o1), 32'd1);
            tick();
            check($sformatf("c_ov_e%0d", k + 1), 32'(c_ov), 32'(ov_exp[k]));
        end
        check("c_cnt", 32'(c_cnt), 32'd2);

        // Three samples in flight, then a one-cycle reset flush.
        c_iv = 1'b1;
        tick(); tick(); tick();
        check("c_pre_rst_ov", 32'(c_ov), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0; c_iv = 1'b0;
        check("flush_q", 32'(c_q), 32'd0);
        check("flush_ov", 32'(c_ov), 32'd0);
        check("flush_cnt", 32'(c_cnt), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("flush_ov_%0d", k), 32'(c_ov), 32'd0);
            check($sformatf("flush_q_%0d", k), 32'(c_q), 32'd0);
        end

        // Saturation on a 3-bit counter.
        d_aa = 1'b1; d_bb = 1'b1; d_iv = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("sat_cnt_%0d", k), 32'(d_cnt), (k > 7) ? 32'd7 : 32'(k));
        end
        check("sat_all", 32'(d_all), 32'd1);
        d_iv = 1'b0;
        tick();
        check("sat_hold", 32'(d_cnt), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
